mcpu_boot_loader: RTL
=====================

// Module: mcpu_boot_loader
// PURPOSE
//  Hardware program loader for the MCPU. Clears program RAM, then accepts a
//  valid/ready stream of instruction words and writes them to consecutive RAM addresses.
//  Holds the CPU in reset until loading completes, then releases it.
//  Sits between an external stream source (UART/bench) and the MCPU RAM write port.
// PARAMETERS
//  WORD_SIZE       16   instruction/RAM word width
//  ADDR_SIZE       8    RAM address width
//  DEPTH           256  RAM words; 1 <= DEPTH <= 2**ADDR_SIZE
//  CLEAR_EN        1    1: zero all DEPTH words before loading; 0: skip clear
//  CPU_RESET_HOLD  2    cycles cpu_reset stays high after the final load write
// PORTS
//  clk         in   1               rising-edge clock
//  reset       in   1               asynchronous reset, active-high
//  reload      in   1               restart the whole sequence (CLEAR or LOAD)
//  in_valid    in   1               stream word present
//  in_ready    out  1               loader accepts word (combinational)
//  in_word     in   WORD_SIZE       instruction word
//  in_last     in   1               marks final word of program
//  mem_we      out  1               RAM write strobe (registered)
//  mem_addr    out  ADDR_SIZE       RAM write address (registered)
//  mem_wdata   out  WORD_SIZE       RAM write data (registered)
//  cpu_reset   out  1               active-high reset to MCPU (registered)
//  done        out  1               program loaded, CPU running
//  error       out  1               overflow: DEPTH words written without in_last
//  word_count  out  ADDR_SIZE+1     words accepted in current load
// BEHAVIOUR
//  - Async reset: state=CLEAR (LOAD if CLEAR_EN=0), ptr=0, mem_we=0, mem_addr=0,
//    mem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0, hold counter=0.
//  - States: CLEAR -> LOAD -> HOLD -> RUN; LOAD -> ERR on overflow.
//  - CLEAR: each cycle register mem_we=1, mem_addr=ptr, mem_wdata=0; ptr++.
//    Exactly DEPTH consecutive strobes, addresses 0..DEPTH-1. After issuing
//    addr DEPTH-1: ptr=0, go LOAD. in_ready=0.
//  - LOAD: in_ready = ~reload. Accept on in_valid & in_ready at edge k.
//    mem_we=1, mem_addr=ptr, mem_wdata=in_word in the cycle after edge k.
//    ptr++, word_count++. No accept -> mem_we=0 next cycle. Gaps are legal.
//  - Accept with in_last=1 -> HOLD. Accept at ptr==DEPTH-1 with in_last=0 ->
//    ERR (word is still written). in_last on word DEPTH-1 -> HOLD.
//  - HOLD: in_ready=0; count CPU_RESET_HOLD cycles. Then RUN.
//    cpu_reset falls exactly CPU_RESET_HOLD+1 cycles after the final write strobe.
//    CPU_RESET_HOLD=0 -> cpu_reset falls in the cycle after the final strobe.
//  - RUN: cpu_reset=0, done=1, in_ready=0, mem_we=0.
//  - ERR: error=1, cpu_reset=1, done=0, in_ready=0. Leave only via reset/reload.
//  - reload (any state, sampled at edge): next cycle cpu_reset=1, done=0,
//    error=0, word_count=0, ptr=0, mem_we=0, state=CLEAR (or LOAD).
//    reload beats a same-cycle accept; in_ready is already 0, so no word is lost.
//  - Reset mid-CLEAR/LOAD: all outputs take reset values immediately, no clock needed.
//    Partial RAM contents are not tracked.
//  - ptr never wraps. The ERR transition prevents a write beyond DEPTH-1.
// STRUCTURE
//  - mcpu_pkg: loader state encoding (CLEAR, LOAD, HOLD, RUN, ERR) and shared
//    WORD_SIZE/ADDR_SIZE defaults, also used by MCPU.
//  - Single module; no sub-module. ptr, hold counter and word_count are local registers.
// TESTING
//  1 Reset, DEPTH=256, CLEAR_EN=1 -> 256 strobes with wdata=0, addr 0..255
//    consecutive; in_ready=0 throughout; in_ready=1 the cycle after.
//  2 Stream the 10-word Fibonacci program, in_last on word 10 -> writes addr 0..9
//    in order, data matches; cpu_reset falls 3 cycles after the addr-9 strobe
//    (HOLD=2); done=1, word_count=10.
//  3 Random in_valid gaps on a 6-word program -> exactly 6 strobes, no duplicate
//    or missing address, and no strobe while idle.
//  4 DEPTH=4, five words, no in_last -> 4 strobes (addr 0..3); error=1; the 5th
//    word sees in_ready=0; cpu_reset stays 1.
//  5 reload in RUN -> next cycle cpu_reset=1, done=0; CLEAR restarts at addr 0;
//    a second program then loads correctly.
//  6 reset asserted mid-LOAD (word_count=3) between edges -> cpu_reset=1,
//    mem_we=0, word_count=0 asynchronously; CLEAR restarts after release.

Source files
------------

// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared MCPU word/address defaults and boot loader state encoding
package mcpu_pkg;
  localparam int WORD_SIZE_DEF = 16;
  localparam int ADDR_SIZE_DEF = 8;
  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;
endpackage

// File: rtl/mcpu_boot_loader.sv
// mcpu_boot_loader: clears program RAM, loads a valid/ready word stream into it, then releases the MCPU from reset
module mcpu_boot_loader
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter int DEPTH          = 256,
  parameter int CLEAR_EN       = 1,
  parameter int CPU_RESET_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reload,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_word,
  input  logic                 in_last,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   word_count
);
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(DEPTH - 1);
  localparam logic [2:0]           START = (CLEAR_EN != 0) ? ST_CLEAR : ST_LOAD;
  localparam int                   HW    = $clog2(CPU_RESET_HOLD + 1) + 1;
  localparam logic [HW-1:0]        HOLD_N = HW'(CPU_RESET_HOLD);
  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [ADDR_SIZE:0]   word_count_q, word_count_d;
  logic                 accept;
  // reload masks in_ready so a word offered alongside reload is never consumed
  assign in_ready   = (state_q == ST_LOAD) & ~reload;
  assign accept     = in_valid & in_ready;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    word_count_d = word_count_q;
    if (reload) begin
      state_d      = START;
      ptr_d        = '0;
      hold_d       = '0;
      cpu_reset_d  = 1'b1;
      done_d       = 1'b0;
      error_d      = 1'b0;
      word_count_d = '0;
    end else if (state_q == ST_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ptr_q;
      mem_wdata_d = '0;
      ptr_d       = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      state_d     = (ptr_q == LAST) ? ST_LOAD : ST_CLEAR;
    end else if (accept) begin
      mem_we_d     = 1'b1;
      mem_addr_d   = ptr_q;
      mem_wdata_d  = in_word;
      word_count_d = word_count_q + 1'b1;
      // ptr saturates at the last word; ERR or HOLD follows so it is never reused
      ptr_d        = (ptr_q == LAST) ? ptr_q : ptr_q + 1'b1;
      hold_d       = '0;
      state_d      = in_last ? ST_HOLD : (ptr_q == LAST) ? ST_ERR : ST_LOAD;
      error_d      = ~in_last & (ptr_q == LAST);
    end else if (state_q == ST_HOLD) begin
      hold_d = (hold_q == HOLD_N) ? hold_q : hold_q + 1'b1;
      if (hold_q == HOLD_N) begin
        state_d     = ST_RUN;
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= START;
      ptr_q        <= '0;
      hold_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
    end
  end
endmodule
